// File: rtl/uart_frame_parser_if.sv
// Byte-in / frame-out bundle for uart_frame_parser.
//   master : byte source + frame consumer (drives byte_valid, byte_data, frame_ready)
//   slave  : the parser (drives frame_valid, frame_cmd, frame_len, frame_payload, err_*)
// MAX_LEN must match the parser's MAX_LEN.
interface uart_frame_parser_if #(
  parameter int unsigned MAX_LEN = 4
);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  logic                   byte_valid;
  logic [7:0]             byte_data;
  logic                   frame_ready;
  logic                   frame_valid;
  logic [7:0]             frame_cmd;
  logic [LEN_W-1:0]       frame_len;
  logic [8*MAX_LEN-1:0]   frame_payload;
  logic                   err_checksum;
  logic                   err_length;
  logic                   err_timeout;
  logic                   err_overrun;

  modport master (
    output byte_valid, byte_data, frame_ready,
    input  frame_valid, frame_cmd, frame_len, frame_payload,
    input  err_checksum, err_length, err_timeout, err_overrun
  );

  modport slave (
    input  byte_valid, byte_data, frame_ready,
    output frame_valid, frame_cmd, frame_len, frame_payload,
    output err_checksum, err_length, err_timeout, err_overrun
  );
endinterface

// File: rtl/uart_frame_parser.sv
// Parses SYNC, CMD, LEN, payload[LEN], CHK frames from a UART byte stream.
// CHK is the XOR of CMD, LEN and every payload byte. A checked frame is held
// on the frame outputs until frame_valid & frame_ready.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : uart_frame_parser_if.slave
//           byte_valid/byte_data in, frame_ready in,
//           frame_valid/cmd/len/payload out, err_checksum/length/timeout/overrun pulses out
module uart_frame_parser #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hAA,
  parameter int unsigned MAX_LEN        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_frame_parser_if.slave    bus
);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {StHunt, StCmd, StLen, StPayload, StCheck, StHold} state_e;

  state_e                        state_q;
  logic [7:0]                    cmd_q;
  logic [7:0]                    chk_q;
  logic [LEN_W-1:0]              len_q;
  logic [LEN_W-1:0]              cnt_q;
  logic [MAX_LEN-1:0][7:0]       payload_q;
  logic [TO_W-1:0]               idle_q;

  logic                          frame_valid_q;
  logic [7:0]                    frame_cmd_q;
  logic [LEN_W-1:0]              frame_len_q;
  logic [8*MAX_LEN-1:0]          frame_payload_q;
  logic                          err_checksum_q;
  logic                          err_length_q;
  logic                          err_timeout_q;
  logic                          err_overrun_q;

  logic in_frame;
  assign in_frame = (state_q == StCmd) || (state_q == StLen) ||
                    (state_q == StPayload) || (state_q == StCheck);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= StHunt;
      cmd_q           <= '0;
      chk_q           <= '0;
      len_q           <= '0;
      cnt_q           <= '0;
      payload_q       <= '0;
      idle_q          <= '0;
      frame_valid_q   <= 1'b0;
      frame_cmd_q     <= '0;
      frame_len_q     <= '0;
      frame_payload_q <= '0;
      err_checksum_q  <= 1'b0;
      err_length_q    <= 1'b0;
      err_timeout_q   <= 1'b0;
      err_overrun_q   <= 1'b0;
    end else begin
      err_checksum_q <= 1'b0;
      err_length_q   <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_overrun_q  <= 1'b0;

      unique case (state_q)
        StHunt: begin
          if (bus.byte_valid && (bus.byte_data == SYNC_BYTE)) begin
            state_q <= StCmd;
          end
        end
        StCmd: begin
          if (bus.byte_valid) begin
            cmd_q   <= bus.byte_data;
            chk_q   <= bus.byte_data;
            state_q <= StLen;
          end
        end
        StLen: begin
          if (bus.byte_valid) begin
            chk_q     <= chk_q ^ bus.byte_data;
            len_q     <= bus.byte_data[LEN_W-1:0];
            cnt_q     <= '0;
            // Cleared here so bytes beyond LEN read back as zero.
            payload_q <= '0;
            if (bus.byte_data > 8'(MAX_LEN)) begin
              err_length_q <= 1'b1;
              state_q      <= StHunt;
            end else if (bus.byte_data == 8'd0) begin
              state_q <= StCheck;
            end else begin
              state_q <= StPayload;
            end
          end
        end
        StPayload: begin
          if (bus.byte_valid) begin
            for (int i = 0; i < int'(MAX_LEN); i++) begin
              if (cnt_q == LEN_W'(i)) payload_q[i] <= bus.byte_data;
            end
            chk_q <= chk_q ^ bus.byte_data;
            cnt_q <= cnt_q + LEN_W'(1);
            if (cnt_q == len_q - LEN_W'(1)) state_q <= StCheck;
          end
        end
        StCheck: begin
          if (bus.byte_valid) begin
            if (bus.byte_data == chk_q) begin
              state_q         <= StHold;
              frame_valid_q   <= 1'b1;
              frame_cmd_q     <= cmd_q;
              frame_len_q     <= len_q;
              frame_payload_q <= payload_q;
            end else begin
              err_checksum_q <= 1'b1;
              state_q        <= StHunt;
            end
          end
        end
        StHold: begin
          // Bytes arriving while a frame is held are dropped.
          if (bus.byte_valid) err_overrun_q <= 1'b1;
          if (frame_valid_q && bus.frame_ready) begin
            frame_valid_q <= 1'b0;
            state_q       <= StHunt;
          end
        end
        default: state_q <= StHunt;
      endcase

      // Inter-byte idle timer, only running inside a frame.
      if (in_frame && !bus.byte_valid) begin
        if (idle_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          err_timeout_q <= 1'b1;
          state_q       <= StHunt;
          idle_q        <= '0;
        end else begin
          idle_q <= idle_q + TO_W'(1);
        end
      end else begin
        idle_q <= '0;
      end
    end
  end

  assign bus.frame_valid   = frame_valid_q;
  assign bus.frame_cmd     = frame_cmd_q;
  assign bus.frame_len     = frame_len_q;
  assign bus.frame_payload = frame_payload_q;
  assign bus.err_checksum  = err_checksum_q;
  assign bus.err_length    = err_length_q;
  assign bus.err_timeout   = err_timeout_q;
  assign bus.err_overrun   = err_overrun_q;

endmodule

// File: doc/uart_frame_parser.md
UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hAA, frame start marker.
REQ-002 SHALL have parameter MAX_LEN, default 4, maximum payload bytes per frame.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 5_000_000, maximum idle clk cycles between bytes inside a frame.
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port byte_valid  input  1  one-cycle pulse marking a received byte, driven by the UART receiver's finished output.
REQ-007 SHALL have port byte_data  input  8  received byte, sampled only when byte_valid=1.
REQ-008 SHALL have port frame_ready  input  1  consumer accepts the frame when high together with frame_valid.
REQ-009 SHALL have port frame_valid  output  1  a checked frame is held on the frame outputs.
REQ-010 SHALL have port frame_cmd  output  8  command byte of the held frame.
REQ-011 SHALL have port frame_len  output  $clog2(MAX_LEN+1)  payload byte count of the held frame.
REQ-012 SHALL have port frame_payload  output  8*MAX_LEN  payload; byte i at bits [8i+7:8i]; bytes at index >= frame_len read 0.
REQ-013 SHALL have ports err_checksum, err_length, err_timeout, err_overrun  output  1 each  one-cycle error pulses.

Function
REQ-014 Frame format SHALL be: SYNC_BYTE, CMD, LEN, LEN payload bytes, CHK; CHK = XOR of CMD, LEN and all payload bytes.
REQ-015 States SHALL be HUNT, CMD, LEN, PAYLOAD, CHECK, HOLD; only byte_valid cycles advance HUNT..CHECK.
REQ-016 HUNT: byte equal to SYNC_BYTE -> CMD; any other byte ignored, no error.
REQ-017 CMD: store byte as command, start running XOR with it -> LEN.
REQ-018 LEN: LEN > MAX_LEN -> err_length pulse, -> HUNT; LEN = 0 -> CHECK; otherwise -> PAYLOAD; LEN is XORed into the running checksum.
REQ-019 PAYLOAD: store byte at index counter (0 first), XOR into checksum, increment counter; after byte LEN-1 -> CHECK.
REQ-020 CHECK: byte equal to running XOR -> HOLD, else err_checksum pulse -> HUNT.
REQ-021 Entering HOLD SHALL copy cmd, len and payload (unused bytes zeroed) to the frame outputs and set frame_valid the cycle after the CHK byte's byte_valid.
REQ-022 HOLD: frame outputs SHALL stay stable while frame_valid=1 and frame_ready=0; on frame_valid&frame_ready frame_valid clears next cycle and state -> HUNT.
REQ-023 Any byte_valid in HOLD (including the handshake cycle) SHALL be dropped and pulse err_overrun; frame outputs unaffected.
REQ-024 In CMD, LEN, PAYLOAD, CHECK an idle counter SHALL clear on every byte_valid and increment otherwise; reaching TIMEOUT_CYCLES -> err_timeout pulse, -> HUNT; counter inactive in HUNT and HOLD.
REQ-025 A SYNC_BYTE value arriving mid-frame SHALL be treated as data (no resynchronisation).
REQ-026 Error pulses SHALL be registered, high exactly one cycle, the cycle after the triggering event; frame_valid never asserts for a failed frame.
REQ-027 Frame outputs SHALL change only on entry to HOLD or reset.

Reset
REQ-028 reset SHALL immediately force state HUNT, clear counters and running XOR, and drive frame_valid, frame_cmd, frame_len, frame_payload and all err_* to 0.
REQ-029 Reset mid-frame SHALL discard the partial frame; the next frame after release SHALL parse normally.

Verification
REQ-030 Bytes AA 01 02 10 20 33 -> frame_valid=1 one cycle after last byte_valid, frame_cmd=01, frame_len=2, frame_payload=32'h0000_2010; held until frame_ready.
REQ-031 Bytes 55 AA 05 00 05 -> 55 ignored, frame_valid, frame_cmd=05, frame_len=0, frame_payload=0.
REQ-032 Bytes AA 01 01 7F 00 -> err_checksum single pulse, no frame_valid; following AA 01 01 7F 7F -> valid frame, payload byte0=7F.
REQ-033 Bytes AA 01 05 -> err_length pulse, state HUNT; bytes 02 03 produce no output.
REQ-034 TIMEOUT_CYCLES=100, bytes AA 01 then no byte_valid -> err_timeout after 100 idle cycles; then full valid frame accepted.
REQ-035 frame_ready=0 while frame held, extra byte 44 arrives -> err_overrun, outputs unchanged; assert reset mid-payload -> all outputs 0 asynchronously.
